// File: rtl/rv32i_pkg.sv
// Shared RV32I front-end definitions: NOP encoding, PC step, reset PC
// and the fetch-buffer entry layout.
package rv32i_pkg;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
    localparam int unsigned PC_STEP = 4;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small in-order fetch buffer with synchronous clear and an
// empty-FIFO bypass so a pushed word can be popped in the same cycle.
module fetch_fifo
    import rv32i_pkg::*;
#(
    parameter int FIFO_DEPTH = 2,
    parameter type entry_t = fetch_entry_t,
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1),
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             push,
    input  logic             pop,
    input  entry_t           push_data,
    output entry_t           head,
    output logic [CNT_W-1:0] count,
    output logic             empty,
    output logic             full
);

    entry_t mem [FIFO_DEPTH];

    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic             bypass;
    logic             do_read;
    logic             do_write;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign empty    = (count == '0);
    assign full     = (count == CNT_W'(FIFO_DEPTH));
    assign bypass   = empty && push && pop;
    assign do_read  = pop && !empty;
    assign do_write = push && !bypass && (!full || do_read);
    assign head     = empty ? push_data : mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_write) begin
                wr_ptr <= next_ptr(wr_ptr);
            end
            if (do_read) begin
                rd_ptr <= next_ptr(rd_ptr);
            end
            count <= count + CNT_W'(do_write) - CNT_W'(do_read);
        end
    end

    // Storage needs no reset: count gates every read.
    always_ff @(posedge clk) begin
        if (do_write && !clear) begin
            mem[wr_ptr] <= push_data;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// RV32I instruction-fetch stage driving the IF/ID register.
// Optional IF_MISALIGN_EN adds misalign_id and halts on unaligned redirects.
module fetch_unit
    import rv32i_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC = ADDR_WIDTH'(DEFAULT_RESET_PC),
    parameter int FIFO_DEPTH = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  pc_en,
    input  logic                  redirect_valid,
    input  logic [ADDR_WIDTH-1:0] redirect_pc,
    output logic                  imem_req,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    input  logic                  imem_gnt,
    input  logic                  imem_rvalid,
    input  logic [DATA_WIDTH-1:0] imem_rdata,
    output logic [DATA_WIDTH-1:0] instruction_id,
    output logic [ADDR_WIDTH-1:0] pc_id,
    output logic                  valid_id
`ifdef IF_MISALIGN_EN
    ,
    output logic                  misalign_id
`endif
);

    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam logic [ADDR_WIDTH-1:0] STEP = ADDR_WIDTH'(PC_STEP);
    localparam logic [DATA_WIDTH-1:0] NOP = DATA_WIDTH'(NOP_INSTR);

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] pc;
        logic [DATA_WIDTH-1:0] instr;
    } entry_t;

    logic [ADDR_WIDTH-1:0] pc_f;
    logic [ADDR_WIDTH-1:0] resp_pc;
    logic [ADDR_WIDTH-1:0] target;
    logic [CNT_W-1:0]      outstanding;
    logic [CNT_W-1:0]      drop_cnt;
    logic [CNT_W-1:0]      fifo_count;
    logic [CNT_W:0]        in_use;
    logic                  fifo_empty;
    logic                  fifo_full;
    logic                  fifo_push;
    logic                  fifo_pop;
    logic                  credit;
    logic                  fire;
    logic                  accept;
    logic                  halt;
    entry_t                push_data;
    entry_t                head;

    // Outstanding requests plus buffered words never exceed the FIFO size,
    // so every response has a slot waiting for it.
    assign in_use    = {1'b0, outstanding} + {1'b0, fifo_count};
    assign credit    = in_use < (CNT_W + 1)'(FIFO_DEPTH);
    assign target    = {redirect_pc[ADDR_WIDTH-1:2], 2'b00};
    assign imem_req  = credit && !redirect_valid && !halt && !rst;
    assign imem_addr = pc_f;
    assign fire      = imem_req && imem_gnt;
    assign accept    = imem_rvalid && (drop_cnt == '0);
    assign fifo_push = accept && !redirect_valid;
    assign fifo_pop  = pc_en && !redirect_valid && (!fifo_empty || fifo_push);
    assign push_data = '{pc: resp_pc, instr: imem_rdata};

`ifdef IF_MISALIGN_EN
    logic misaligned;

    assign misaligned = |redirect_pc[1:0];
    assign halt       = misalign_id;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            misalign_id <= 1'b0;
        end else if (redirect_valid) begin
            misalign_id <= misaligned;
        end
    end
`else
    logic unused_low_bits;

    assign unused_low_bits = ^redirect_pc[1:0];
    assign halt            = 1'b0;
`endif

    fetch_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH),
        .entry_t    (entry_t)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .clear     (redirect_valid),
        .push      (fifo_push),
        .pop       (fifo_pop),
        .push_data (push_data),
        .head      (head),
        .count     (fifo_count),
        .empty     (fifo_empty),
        .full      (fifo_full)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_f        <= RESET_PC;
            resp_pc     <= RESET_PC;
            outstanding <= '0;
            drop_cnt    <= '0;
        end else begin
            outstanding <= outstanding + CNT_W'(fire) - CNT_W'(imem_rvalid);
            if (redirect_valid) begin
                pc_f    <= target;
                resp_pc <= target;
                // Whatever is still in flight after this cycle is stale.
                drop_cnt <= outstanding - CNT_W'(imem_rvalid);
            end else begin
                if (fire) begin
                    pc_f <= pc_f + STEP;
                end
                if (accept) begin
                    resp_pc <= resp_pc + STEP;
                end
                if (imem_rvalid && (drop_cnt != '0)) begin
                    drop_cnt <= drop_cnt - CNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            instruction_id <= NOP;
            pc_id          <= '0;
            valid_id       <= 1'b0;
        end else if (redirect_valid) begin
            instruction_id <= NOP;
            valid_id       <= 1'b0;
`ifdef IF_MISALIGN_EN
            if (misaligned) begin
                pc_id <= redirect_pc;
            end
`endif
        end else if (pc_en) begin
            if (fifo_pop) begin
                instruction_id <= head.instr;
                pc_id          <= head.pc;
                valid_id       <= 1'b1;
            end else begin
                instruction_id <= NOP;
                valid_id       <= 1'b0;
            end
        end
    end

    a_no_spurious_rvalid : assert property (
        @(posedge clk) disable iff (rst)
        !(imem_rvalid && (outstanding == '0))
    );

    a_no_overflow : assert property (
        @(posedge clk) disable iff (rst)
        !(fifo_push && fifo_full && !fifo_pop)
    );

endmodule
